// File: rtl/credit_pkg.sv
// ---------------------------------------------------------------------------
// credit_pkg
//   Shared types and helpers for the credit-based link (sender and receiver).
//   - credit_state_e : sender FSM states (RUN, ERR)
//   - CRED_W_DEFAULT : default credit counter width
//   - credit_next()  : credit arithmetic (avail - dec + inc) with one
//                      headroom bit, so an overflow stays visible
// ---------------------------------------------------------------------------
package credit_pkg;

  typedef enum logic {
    CS_RUN = 1'b0,
    CS_ERR = 1'b1
  } credit_state_e;

  localparam int CRED_W_DEFAULT = 4;

  // The helper works at a fixed generous width. Callers truncate the result
  // to CRED_W+1 bits. The arithmetic is modular, so truncation gives the same
  // value as computing directly in CRED_W+1 bits.
  localparam int CRED_FN_W = 16;

  function automatic logic [CRED_FN_W:0] credit_next(
    input logic [CRED_FN_W-1:0] avail,
    input logic                 dec,
    input logic [CRED_FN_W-1:0] inc
  );
    return {1'b0, avail} - {{CRED_FN_W{1'b0}}, dec} + {1'b0, inc};
  endfunction

endpackage

// File: rtl/credit_counter.sv
// ---------------------------------------------------------------------------
// credit_counter
//   Saturating up/down credit counter with overflow detect. It is shared by
//   the send side and the receive side of the credit link.
//   Ports:
//     clk, rst : clock and synchronous active-high reset (count <= MAX_CREDITS)
//     dec      : consume one credit this cycle
//     inc      : number of credits returned this cycle
//     en       : counter updates only while en=1 (frozen otherwise)
//     count    : current credit count
//     ovf      : combinational; the update this cycle would exceed MAX_CREDITS
// ---------------------------------------------------------------------------
module credit_counter
  import credit_pkg::*;
#(
  parameter int MAX_CREDITS = 8,
  parameter int CRED_W      = CRED_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec,
  input  logic [CRED_W-1:0] inc,
  input  logic              en,
  output logic [CRED_W-1:0] count,
  output logic              ovf
);

  localparam logic [CRED_W:0] MAX_W = (CRED_W+1)'(MAX_CREDITS);

  logic [CRED_W-1:0] count_q;
  logic [CRED_W-1:0] count_d;
  logic [CRED_W:0]   next_sum;

  always_comb begin
    next_sum = (CRED_W+1)'(credit_next({{(CRED_FN_W-CRED_W){1'b0}}, count_q},
                                       dec,
                                       {{(CRED_FN_W-CRED_W){1'b0}}, inc}));
    ovf      = en && (next_sum > MAX_W);
    count_d  = count_q;
    if (en) begin
      // On overflow the count pins at full rather than wrapping.
      count_d = ovf ? MAX_W[CRED_W-1:0] : next_sum[CRED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MAX_W[CRED_W-1:0];
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/credit_sender.sv
// ---------------------------------------------------------------------------
// credit_sender
//   Transmit side of a credit-gated link. Upstream words arrive on a
//   valid/ready port. They are forwarded one cycle later on out_valid/out_data.
//   The downstream side has no ready; credits from the receiver gate it.
//   Ports:
//     clk, rst     : clock and synchronous active-high reset
//     in_valid/in_ready/in_data : upstream handshake
//     out_valid/out_data        : downstream strobe and payload (registered)
//     credit_ret   : credits returned by the receiver this cycle
//     credit_avail : current credit count
//     link_idle    : all credits home and nothing on the wire
//     credit_err   : sticky flag, receiver returned more credits than it had
//     dbg_state    : FSM state (0 = RUN, 1 = ERR)
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
//   in_ready depends only on registers: it is high in RUN with at least one
//   credit. It never looks at in_valid or credit_ret. A producer may hold
//   in_valid/in_data while in_ready is low. Credits returned in a cycle
//   become usable from the following cycle.
// ---------------------------------------------------------------------------
module credit_sender
  import credit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8,
  parameter int CRED_W      = CRED_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [CRED_W-1:0]     credit_ret,
  output logic [CRED_W-1:0]     credit_avail,
  output logic                  link_idle,
  output logic                  credit_err,
  output logic                  dbg_state
);

  localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_CREDITS);

  credit_state_e         state_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  credit_err_q;
  logic [CRED_W-1:0]     count;
  logic                  ovf;
  logic                  send;
  logic                  run;

  assign run      = (state_q == CS_RUN);
  assign in_ready = run && (count != '0);
  assign send     = in_valid && in_ready;

  // Counter freezes in ERR, so credit_ret is ignored there.
  credit_counter #(
    .MAX_CREDITS (MAX_CREDITS),
    .CRED_W      (CRED_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .dec   (send),
    .inc   (credit_ret),
    .en    (run),
    .count (count),
    .ovf   (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CS_RUN;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      // The send that triggers an overflow is still forwarded.
      out_valid_q <= send;
      if (send) begin
        out_data_q <= in_data;
      end
      if (ovf) begin
        state_q      <= CS_ERR;
        credit_err_q <= 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign credit_avail = count;
  assign credit_err   = credit_err_q;
  assign link_idle    = (count == MAX_C) && !out_valid_q;
  assign dbg_state    = (state_q == CS_ERR);

endmodule
